// File: rtl/uart_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } uart_state_t;

  localparam logic [2:0] UART_TXDATA_OFS = 3'd0;
  localparam logic [2:0] UART_STATUS_OFS = 3'd4;

  localparam int ST_FULL  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_BUSY  = 2;
  localparam int ST_OVF   = 3;
  localparam int ST_PAR   = 4;

  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with first-word-fall-through read data.
// A push into a full FIFO is still taken when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = DEPTH + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push_s;
  logic             do_pop_s;

  assign full_o    = (cnt_q == CNT_W'(DEPTH));
  assign empty_o   = (cnt_q == {CNT_W{1'b0}});
  assign rdata_o   = mem_q[rd_ptr_q];
  assign do_pop_s  = pop_i & ~empty_o;
  assign do_push_s = push_i & (~full_o | do_pop_s);

  // Pointer and occupancy next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push_s) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    else           wr_ptr_d = wr_ptr_q;
    if (do_pop_s)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    else           rd_ptr_d = rd_ptr_q;
    case ({do_push_s, do_pop_s})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage and pointer registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      cnt_q    <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= {WIDTH{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      if (do_push_s) mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Bus-attached UART transmitter: TXDATA/STATUS window, TX FIFO, 8N1 serialiser.
// Define MMIO_UART_PARITY_EN to add an even-parity bit (8E1 framing).
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0040,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_MemWrite,
  input  logic [31:0] i_DataAddr,
  input  logic [31:0] i_WriteData,
  output logic        o_sel,
  output logic [31:0] o_ReadData,
  output logic        o_tx,
  output logic        o_busy
);

  localparam int                BAUD_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(CLKS_PER_BIT - 1);

  uart_state_t       state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              ovf_q, ovf_d;
`ifdef MMIO_UART_PARITY_EN
  logic              par_q, par_d;
`endif

  logic        is_status_s;
  logic        wr_txdata_s;
  logic        wr_status_s;
  logic        fifo_pop_s;
  logic        fifo_full_s;
  logic        fifo_empty_s;
  logic [7:0]  fifo_rdata_s;
  logic        baud_end_s;
  logic        ovf_set_s;
  logic        ovf_clr_s;
  logic [31:0] status_s;
  logic        unused_s;

  assign o_sel       = (i_DataAddr[31:3] == BASE_ADDR[31:3]);
  assign is_status_s = ({i_DataAddr[2], 2'b00} == UART_STATUS_OFS);
  assign wr_txdata_s = o_sel & i_MemWrite & ~is_status_s;
  assign wr_status_s = o_sel & i_MemWrite & is_status_s;
  assign baud_end_s  = (baud_q == BAUD_MAX);
  assign ovf_set_s   = wr_txdata_s & fifo_full_s & ~fifo_pop_s;
  assign ovf_clr_s   = wr_status_s & i_WriteData[ST_OVF];
  assign o_busy      = (state_q != S_IDLE) | ~fifo_empty_s;
  assign o_tx        = tx_q;
  assign unused_s    = ^{i_DataAddr[1:0], i_WriteData[31:8]};

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (wr_txdata_s),
    .wdata_i (i_WriteData[7:0]),
    .pop_i   (fifo_pop_s),
    .rdata_o (fifo_rdata_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  // Status word and register read mux
  always_comb begin
    status_s           = 32'd0;
    status_s[ST_FULL]  = fifo_full_s;
    status_s[ST_EMPTY] = fifo_empty_s;
    status_s[ST_BUSY]  = o_busy;
    status_s[ST_OVF]   = ovf_q;
`ifdef MMIO_UART_PARITY_EN
    status_s[ST_PAR]   = 1'b1;
`endif
    if (o_sel && is_status_s) o_ReadData = status_s;
    else                      o_ReadData = 32'd0;
  end

  // Sticky overflow: a new drop outranks a simultaneous clear
  always_comb begin
    ovf_d = ovf_q;
    if (ovf_set_s)      ovf_d = 1'b1;
    else if (ovf_clr_s) ovf_d = 1'b0;
    else                ovf_d = ovf_q;
  end

  // Frame sequencer, baud counter and bit counter
  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    fifo_pop_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty_s) begin
          fifo_pop_s = 1'b1;
          shift_d    = fifo_rdata_s;
          baud_d     = {BAUD_W{1'b0}};
          state_d    = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (baud_end_s) begin
          baud_d  = {BAUD_W{1'b0}};
          bit_d   = 3'd0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      S_DATA: begin
        if (baud_end_s) begin
          baud_d = {BAUD_W{1'b0}};
          if (bit_q == 3'd7) begin
`ifdef MMIO_UART_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
`ifdef MMIO_UART_PARITY_EN
      S_PARITY: begin
        if (baud_end_s) begin
          baud_d  = {BAUD_W{1'b0}};
          state_d = S_STOP;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
`endif
      S_STOP: begin
        if (baud_end_s) begin
          baud_d = {BAUD_W{1'b0}};
          if (!fifo_empty_s) begin
            fifo_pop_s = 1'b1;
            shift_d    = fifo_rdata_s;
            state_d    = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: begin
        baud_d  = {BAUD_W{1'b0}};
        state_d = S_IDLE;
      end
    endcase
  end

`ifdef MMIO_UART_PARITY_EN
  // Parity is captured with the byte since the shift register is consumed
  always_comb begin
    if (fifo_pop_s) par_d = even_parity(fifo_rdata_s);
    else            par_d = par_q;
  end
`endif

  // Line level follows the next state so o_tx can come straight from a flop
  always_comb begin
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
`ifdef MMIO_UART_PARITY_EN
      S_PARITY: tx_d = par_d;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  // State registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      baud_q  <= {BAUD_W{1'b0}};
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      tx_q    <= 1'b1;
      ovf_q   <= 1'b0;
`ifdef MMIO_UART_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      ovf_q   <= ovf_d;
`ifdef MMIO_UART_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule
